// File: rtl/led_nios2_qsys_oci_dct_packer.sv
// Packs 3-bit OCI trace codes LSB-first into 30-bit words and hands them
// downstream over valid/ready; the accumulator refills while a word waits.
module led_nios2_qsys_oci_dct_packer #(
    parameter int CODE_W = 3,
    parameter int SLOTS  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    code_valid,
    input  logic [CODE_W-1:0]       code,
    output logic                    code_ready,
    input  logic                    flush,
    output logic                    dct_valid,
    input  logic                    dct_ready,
    output logic [CODE_W*SLOTS-1:0] dct_buffer,
    output logic [3:0]              dct_count
);
    localparam int         DATA_W = CODE_W * SLOTS;
    localparam logic [3:0] FULL   = 4'(SLOTS);

    logic [DATA_W-1:0] acc_data, acc_data_next, base_data;
    logic [3:0]        acc_count, acc_count_next, base_count;
    logic              flush_pend, flush_pend_next;
    logic              out_free, xfer, accept;

    // Transfer decision uses registered state only, so a word reaches the
    // output one cycle after it fills or after the flush is registered.
    assign out_free   = !dct_valid || dct_ready;
    assign xfer       = out_free && ((acc_count == FULL) || (flush_pend && (acc_count != 4'd0)));
    assign code_ready = (acc_count < FULL) || xfer;
    assign accept     = code_valid && code_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        base_data      = xfer ? '0 : acc_data;
        base_count     = xfer ? '0 : acc_count;
        acc_data_next  = base_data;
        acc_count_next = base_count;
        if (accept) begin
            // Slots at or above the count are zero, so OR-ing places the code.
            acc_data_next  = base_data | (DATA_W'(code) << (CODE_W * int'(base_count)));
            acc_count_next = base_count + 4'd1;
        end
        // A flush that would leave nothing in the accumulator is dropped.
        flush_pend_next = (flush_pend && !xfer) || (flush && (acc_count_next != 4'd0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_data   <= '0;
            acc_count  <= '0;
            flush_pend <= 1'b0;
            dct_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            acc_data   <= acc_data_next;
            acc_count  <= acc_count_next;
            flush_pend <= flush_pend_next;
            if (xfer) begin
                dct_buffer <= acc_data;
                dct_count  <= acc_count;
                dct_valid  <= 1'b1;
            end else if (dct_ready && dct_valid) begin
                dct_valid <= 1'b0;
            end
        end
    end
endmodule
